// File: rtl/ref_clk_training_ctrl_if.sv
// Control/status bundle between the CK loopback training controller and its IOD lane / PHY sequencer.
// The controller side uses the master modport; the lane/sequencer side uses slave.
interface ref_clk_training_ctrl_if #(
  parameter int unsigned TAP_W = 7
);
  logic             TRAINING_START;
  logic [7:0]       RX_DATA_0;
  logic             EYE_MONITOR_EARLY_0;
  logic             EYE_MONITOR_LATE_0;
  logic             DELAY_LINE_OUT_OF_RANGE_0;
  logic             DELAY_LINE_LOAD_0;
  logic             DELAY_LINE_MOVE_0;
  logic             DELAY_LINE_DIRECTION_0;
  logic             EYE_MONITOR_CLEAR_FLAGS_0;
  logic             TRAINING_BUSY;
  logic             TRAINING_DONE;
  logic             TRAINING_ERR;
  logic [TAP_W-1:0] TAP_VALUE;
  logic [TAP_W-1:0] EDGE_TAP;

  modport master (
    input  TRAINING_START, RX_DATA_0, EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0,
           DELAY_LINE_OUT_OF_RANGE_0,
    output DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
           EYE_MONITOR_CLEAR_FLAGS_0, TRAINING_BUSY, TRAINING_DONE, TRAINING_ERR,
           TAP_VALUE, EDGE_TAP
  );

  modport slave (
    output TRAINING_START, RX_DATA_0, EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0,
           DELAY_LINE_OUT_OF_RANGE_0,
    input  DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
           EYE_MONITOR_CLEAR_FLAGS_0, TRAINING_BUSY, TRAINING_DONE, TRAINING_ERR,
           TAP_VALUE, EDGE_TAP
  );
endinterface

// File: rtl/ref_clk_training_ctrl.sv
// CK loopback delay-line training: sweeps the RX delay up from tap 0 until the sampled
// clock phase flips, then parks on that tap and reports DONE, or ERR on failure.
module ref_clk_training_ctrl #(
  parameter int unsigned MAX_TAPS      = 128,
  parameter int unsigned TAP_W         = 7,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_COUNT  = 4
) (
  input  logic                          FAB_CLK,
  input  logic                          RESET,
  ref_clk_training_ctrl_if.master       bus
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_COUNT - 1);
  localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(MAX_TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_MOVE, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] edge_tap_q, edge_tap_d;
  logic             ref_valid_q, ref_valid_d;
  logic             ref_phase_q, ref_phase_d;
  logic [7:0]       first_q, first_d;
  logic             ok_q, ok_d;
  logic             dir_q, dir_d;
  logic             load_q, load_d;
  logic             move_q, move_d;
  logic             clear_q, clear_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             stable_now_c;

  // A single capture is usable only for a clean CK pattern with no eye-monitor complaint.
  assign stable_now_c = ((bus.RX_DATA_0 == 8'h55) || (bus.RX_DATA_0 == 8'hAA)) &&
                        !bus.EYE_MONITOR_EARLY_0 && !bus.EYE_MONITOR_LATE_0;

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tap_q       <= '0;
      edge_tap_q  <= '0;
      ref_valid_q <= 1'b0;
      ref_phase_q <= 1'b0;
      first_q     <= '0;
      ok_q        <= 1'b0;
      dir_q       <= 1'b0;
      load_q      <= 1'b0;
      move_q      <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tap_q       <= tap_d;
      edge_tap_q  <= edge_tap_d;
      ref_valid_q <= ref_valid_d;
      ref_phase_q <= ref_phase_d;
      first_q     <= first_d;
      ok_q        <= ok_d;
      dir_q       <= dir_d;
      load_q      <= load_d;
      move_q      <= move_d;
      clear_q     <= clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tap_d       = tap_q;
    edge_tap_d  = edge_tap_q;
    ref_valid_d = ref_valid_q;
    ref_phase_d = ref_phase_q;
    first_d     = first_q;
    ok_d        = ok_q;
    dir_d       = dir_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.TRAINING_START) state_d = S_LOAD;
      end
      S_LOAD: begin
        tap_d       = '0;
        ref_valid_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        // First capture sets the pattern every later capture must repeat.
        if (cnt_q == '0) begin
          first_d = bus.RX_DATA_0;
          ok_d    = stable_now_c;
        end else begin
          ok_d = ok_q && stable_now_c && (bus.RX_DATA_0 == first_q);
        end
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EVAL: begin
        // Last tap is never stepped past, so the tap counter cannot wrap.
        if (bus.DELAY_LINE_OUT_OF_RANGE_0) begin
          state_d = S_ERR;
        end else if (ok_q && !ref_valid_q) begin
          ref_phase_d = first_q[0];
          ref_valid_d = 1'b1;
          state_d     = (tap_q == TAP_LAST) ? S_ERR : S_MOVE;
        end else if (ok_q && (first_q[0] != ref_phase_q)) begin
          edge_tap_d = tap_q;
          state_d    = S_DONE;
        end else if (tap_q == TAP_LAST) begin
          state_d = S_ERR;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        tap_d   = tap_q + TAP_W'(1);
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered images of the state being entered.
    load_d  = (state_d == S_LOAD);
    move_d  = (state_d == S_MOVE);
    clear_d = (state_d == S_SETTLE) && (cnt_d == SETTLE_LAST);
    busy_d  = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    if (state_d == S_LOAD) dir_d = 1'b1;
  end

  assign bus.DELAY_LINE_LOAD_0         = load_q;
  assign bus.DELAY_LINE_MOVE_0         = move_q;
  assign bus.DELAY_LINE_DIRECTION_0    = dir_q;
  assign bus.EYE_MONITOR_CLEAR_FLAGS_0 = clear_q;
  assign bus.TRAINING_BUSY             = busy_q;
  assign bus.TRAINING_DONE             = done_q;
  assign bus.TRAINING_ERR              = err_q;
  assign bus.TAP_VALUE                 = tap_q;
  assign bus.EDGE_TAP                  = edge_tap_q;

endmodule

// File: tb/tb_ref_clk_training_ctrl.sv
// Directed bench for ref_clk_training_ctrl: a small lane model drives RX/eye/range inputs
// from the current tap while pulses and status are counted on the falling edge.
module tb_ref_clk_training_ctrl;
  localparam int unsigned TAP_W = 7;

  localparam int M_CLEAN  = 0;
  localparam int M_JITTER = 1;
  localparam int M_EYE    = 2;
  localparam int M_FLAT   = 3;
  localparam int M_OOR    = 4;

  logic FAB_CLK = 1'b0;
  logic RESET   = 1'b1;

  ref_clk_training_ctrl_if #(.TAP_W(TAP_W)) bus ();

  ref_clk_training_ctrl #(
    .MAX_TAPS(128), .TAP_W(TAP_W), .SETTLE_CYCLES(8), .SAMPLE_COUNT(4)
  ) dut (
    .FAB_CLK (FAB_CLK),
    .RESET   (RESET),
    .bus     (bus.master)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int errors = 0;
  int checks = 0;
  int mode   = M_CLEAN;
  int edge_at = 20;
  logic jit = 1'b0;
  int cyc = 0;
  int n_load, n_move, n_clear, n_overlap, n_spacing;
  int t_load, t_done, last_move;
  bit to;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Lane model: what the deserializer / eye monitor / delay line report at the current tap.
  task automatic drive();
    int tap;
    logic [7:0] d;
    tap = int'(bus.TAP_VALUE);
    jit = ~jit;
    bus.EYE_MONITOR_EARLY_0       = 1'b0;
    bus.EYE_MONITOR_LATE_0        = 1'b0;
    bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    case (mode)
      M_CLEAN:  d = (tap < edge_at) ? 8'h55 : 8'hAA;
      M_JITTER: d = (tap < 10) ? 8'h55 : (tap < 15) ? (jit ? 8'hAA : 8'h55) : 8'hAA;
      M_EYE: begin
        d = (tap == 0) ? 8'hAA : (tap < 5) ? 8'h55 : 8'hAA;
        bus.EYE_MONITOR_EARLY_0 = (tap == 0);
      end
      M_FLAT:   d = 8'hAA;
      default: begin
        d = (tap < 30) ? 8'h55 : 8'hAA;
        bus.DELAY_LINE_OUT_OF_RANGE_0 = (tap >= 30);
      end
    endcase
    bus.RX_DATA_0 = d;
  endtask

  task automatic clear_counts();
    n_load = 0; n_move = 0; n_clear = 0; n_overlap = 0; n_spacing = 0;
    t_load = -1; t_done = -1; last_move = -1000;
  endtask

  task automatic sample();
    int hot;
    hot = int'(bus.DELAY_LINE_LOAD_0) + int'(bus.DELAY_LINE_MOVE_0) +
          int'(bus.EYE_MONITOR_CLEAR_FLAGS_0);
    if (hot > 1) n_overlap++;
    if (bus.DELAY_LINE_LOAD_0) begin
      n_load++;
      if (t_load < 0) t_load = cyc;
    end
    if (bus.DELAY_LINE_MOVE_0) begin
      n_move++;
      if (cyc - last_move < 14) n_spacing++;
      last_move = cyc;
    end
    if (bus.EYE_MONITOR_CLEAR_FLAGS_0) n_clear++;
    if (bus.TRAINING_DONE && t_done < 0) t_done = cyc;
  endtask

  task automatic do_start();
    @(negedge FAB_CLK);
    clear_counts();
    bus.TRAINING_START = 1'b1;
    drive();
  endtask

  // Runs until DONE/ERR or the cycle budget expires; inj injects a start request at that step.
  task automatic run(input int budget, input int inj, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge FAB_CLK);
      cyc++;
      sample();
      if (bus.TRAINING_DONE || bus.TRAINING_ERR) begin
        timed_out = 1'b0;
        break;
      end
      bus.TRAINING_START = (i == inj);
      drive();
    end
    bus.TRAINING_START = 1'b0;
  endtask

  function automatic int out_word();
    return int'({bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0, bus.DELAY_LINE_DIRECTION_0,
                 bus.EYE_MONITOR_CLEAR_FLAGS_0, bus.TRAINING_BUSY, bus.TRAINING_DONE,
                 bus.TRAINING_ERR, bus.TAP_VALUE, bus.EDGE_TAP});
  endfunction

  initial begin
    bus.TRAINING_START            = 1'b0;
    bus.RX_DATA_0                 = 8'h00;
    bus.EYE_MONITOR_EARLY_0       = 1'b0;
    bus.EYE_MONITOR_LATE_0        = 1'b0;
    bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    clear_counts();

    // Power-on reset state
    repeat (3) @(negedge FAB_CLK);
    check("por_outputs", out_word(), 0);
    RESET = 1'b0;

    // Reset asserted mid-SAMPLE clears everything at once and stays quiet afterwards
    mode = M_CLEAN; edge_at = 20;
    do_start();
    run(11, -1, to);
    check("pre_reset_busy", int'(bus.TRAINING_BUSY), 1);
    RESET = 1'b1;
    #1;
    check("midsweep_reset_outputs", out_word(), 0);
    @(negedge FAB_CLK);
    RESET = 1'b0;
    clear_counts();
    run(60, -1, to);
    check("post_reset_idle", int'(to), 1);
    check("post_reset_pulses", n_load + n_move + n_clear, 0);
    check("post_reset_busy", int'(bus.TRAINING_BUSY), 0);

    // Clean edge at tap 20
    mode = M_CLEAN; edge_at = 20;
    do_start();
    run(2000, -1, to);
    check("clean_timeout", int'(to), 0);
    check("clean_loads", n_load, 1);
    check("clean_moves", n_move, 20);
    check("clean_clears", n_clear, 21);
    check("clean_done", int'(bus.TRAINING_DONE), 1);
    check("clean_err", int'(bus.TRAINING_ERR), 0);
    check("clean_busy", int'(bus.TRAINING_BUSY), 0);
    check("clean_edge_tap", int'(bus.EDGE_TAP), 20);
    check("clean_tap_value", int'(bus.TAP_VALUE), 20);
    check("clean_direction", int'(bus.DELAY_LINE_DIRECTION_0), 1);
    check("clean_done_latency", t_done - t_load - 1, 14 * 20 + 13);
    check("clean_pulse_overlap", n_overlap, 0);
    check("clean_move_spacing", n_spacing, 0);

    // Jittery transition region, edge taken at the first stable flipped tap
    mode = M_JITTER;
    do_start();
    run(2000, -1, to);
    check("jitter_timeout", int'(to), 0);
    check("jitter_done", int'(bus.TRAINING_DONE), 1);
    check("jitter_edge_tap", int'(bus.EDGE_TAP), 15);

    // Early flag at tap 0 keeps it from becoming the reference
    mode = M_EYE;
    do_start();
    run(2000, -1, to);
    check("eye_timeout", int'(to), 0);
    check("eye_done", int'(bus.TRAINING_DONE), 1);
    check("eye_edge_tap", int'(bus.EDGE_TAP), 5);

    // No edge anywhere: sweep ends on the last tap
    mode = M_FLAT;
    do_start();
    run(3000, -1, to);
    check("flat_timeout", int'(to), 0);
    check("flat_err", int'(bus.TRAINING_ERR), 1);
    check("flat_done", int'(bus.TRAINING_DONE), 0);
    check("flat_tap_value", int'(bus.TAP_VALUE), 127);
    check("flat_moves", n_move, 127);
    check("flat_move_spacing", n_spacing, 0);

    // Out of range wins over a simultaneous flip; start while busy is ignored
    mode = M_OOR;
    do_start();
    run(2000, 100, to);
    check("oor_timeout", int'(to), 0);
    check("oor_err", int'(bus.TRAINING_ERR), 1);
    check("oor_done", int'(bus.TRAINING_DONE), 0);
    check("oor_tap_value", int'(bus.TAP_VALUE), 30);
    check("oor_busy_start_loads", n_load, 1);
    check("oor_moves", n_move, 30);

    // Restart from ERR
    mode = M_CLEAN; edge_at = 3;
    do_start();
    run(2000, -1, to);
    check("restart_timeout", int'(to), 0);
    check("restart_loads", n_load, 1);
    check("restart_err_cleared", int'(bus.TRAINING_ERR), 0);
    check("restart_done", int'(bus.TRAINING_DONE), 1);
    check("restart_edge_tap", int'(bus.EDGE_TAP), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ref_clk_training_ctrl.md
Name: ref_clk_training_ctrl

Overview:
Fabric-side training controller for the DDR3 reference-clock (CK) loopback IOD lane. It drives the lane's dynamic delay-line and eye-monitor controls, and samples the 8-bit deserialized CK pattern. It sweeps the RX delay upward from tap 0 until the sampled clock phase flips, then parks the delay on that edge tap. TRAINING_DONE/TRAINING_ERR and the edge tap are reported to the DDR PHY training sequencer.

Parameters:
MAX_TAPS, 128, number of delay-line taps; the sweep fails once the tap counter reaches MAX_TAPS-1.
TAP_W, 7, tap counter width; must satisfy 2^TAP_W >= MAX_TAPS.
SETTLE_CYCLES, 8, FAB_CLK cycles to wait after any delay-line load or move before sampling (>=1).
SAMPLE_COUNT, 4, consecutive RX_DATA samples that must agree for a tap to count as stable (>=1).

Ports:
FAB_CLK  in  1  fabric clock; the only clock; RX_DATA_0 is synchronous to it.
RESET  in  1  asynchronous, active-high reset.
TRAINING_START  in  1  single-cycle start request.
RX_DATA_0  in  8  deserialized CK samples.
EYE_MONITOR_EARLY_0  in  1  eye-monitor early flag (sticky until cleared).
EYE_MONITOR_LATE_0  in  1  eye-monitor late flag (sticky until cleared).
DELAY_LINE_OUT_OF_RANGE_0  in  1  delay line at its end stop.
DELAY_LINE_LOAD_0  out  1  one-cycle pulse; reloads the static delay (tap 0).
DELAY_LINE_MOVE_0  out  1  one-cycle pulse; steps the delay by one tap.
DELAY_LINE_DIRECTION_0  out  1  1 = increment.
EYE_MONITOR_CLEAR_FLAGS_0  out  1  one-cycle pulse; clears the sticky eye flags.
TRAINING_BUSY  out  1  high from start acceptance until DONE or ERR.
TRAINING_DONE  out  1  level; high once the edge is found and held until the next start.
TRAINING_ERR  out  1  level; sweep failure, held until the next start.
TAP_VALUE  out  TAP_W  current tap count.
EDGE_TAP  out  TAP_W  tap at which the phase flip was found; valid while DONE is high.

Behaviour:
- Reset (async assert): state IDLE; all outputs 0, including DIRECTION, TAP_VALUE and EDGE_TAP. Internal ref_valid and ref_phase are cleared. Reset mid-sweep aborts immediately, with no further pulses.
- Stable sample definition: RX_DATA_0 is 8'h55 or 8'hAA, and EARLY and LATE are both 0. Phase = RX_DATA_0[0].
- States and transitions:
  - IDLE / DONE / ERR: TRAINING_START=1 -> LOAD. Start is ignored in every other state.
  - LOAD: one cycle. DELAY_LINE_LOAD_0=1; tap <= 0; DONE, ERR and ref_valid cleared; BUSY set; DIRECTION <= 1 and held at 1 until reset -> SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles. On the last cycle, pulse EYE_MONITOR_CLEAR_FLAGS_0 -> SAMPLE.
  - SAMPLE: capture SAMPLE_COUNT consecutive cycles. The tap is stable only if every capture is stable and all captures are equal -> EVAL.
  - EVAL: one cycle, decisions in this priority order:
    1. OUT_OF_RANGE=1 -> ERR.
    2. Stable, !ref_valid -> set ref_phase and ref_valid -> MOVE.
    3. Stable, ref_valid, phase != ref_phase -> EDGE_TAP <= tap -> DONE.
    4. Otherwise (unstable, or same phase): if tap == MAX_TAPS-1 -> ERR; else -> MOVE.
  - MOVE: one cycle. DELAY_LINE_MOVE_0=1; tap <= tap+1 -> SETTLE.
  - DONE: BUSY=0, DONE=1. The delay line is left at EDGE_TAP; no further pulses.
  - ERR: BUSY=0, ERR=1. The delay line is left where it stopped.
- Pulse rules: LOAD, MOVE and CLEAR_FLAGS are each high for exactly one cycle and are mutually exclusive. Consecutive MOVE pulses are separated by at least SETTLE_CYCLES+SAMPLE_COUNT+1 cycles.
- Latency per tap: 1 (MOVE) + SETTLE_CYCLES + SAMPLE_COUNT + 1 (EVAL) cycles. With defaults this is 14.
- Tap counter: saturating by construction, since the ERR check precedes MOVE. It never wraps.
- Simultaneous events: OUT_OF_RANGE takes precedence over a phase flip in the same EVAL. RESET takes precedence over everything.

Test Plan:
1. Reset: assert RESET mid-SAMPLE -> all outputs 0 within the same cycle; no further LOAD/MOVE pulses after deassertion until TRAINING_START.
2. Clean edge: RX_DATA_0=8'h55 for taps 0..19, 8'hAA from tap 20 -> exactly one LOAD, 20 MOVE pulses; DONE=1, EDGE_TAP=20, TAP_VALUE=20, ERR=0. DONE rises at 14*20+13 cycles after LOAD (defaults).
3. Jitter region: 8'h55 at taps 0..9, alternating 8'h55/8'hAA at taps 10..14, 8'hAA from tap 15 -> EDGE_TAP=15.
4. Eye flag: stable 8'hAA at tap 0, but EARLY=1 during SAMPLE -> tap 0 is not used as reference; the first stable tap sets the reference.
5. No edge: RX_DATA_0 held at 8'hAA -> ERR=1 at TAP_VALUE=127 after 127 MOVE pulses; DONE=0.
6. Out of range: OUT_OF_RANGE_0=1 at tap 30, together with a phase flip at tap 30 -> ERR=1, DONE=0. A TRAINING_START issued while BUSY causes no restart; a TRAINING_START from ERR restarts with a LOAD pulse.
